// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data RAM (read latency 1).
// Port A is the processor and port B the debug/uart controller; conflicts alternate round-robin.
module data_mem_arbiter #(
    parameter int unsigned WORD_SIZE  = 18,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_address,
    input  logic [WORD_SIZE-1:0]  a_write,
    output logic                  a_grant,
    output logic                  a_rvalid,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_address,
    input  logic [WORD_SIZE-1:0]  b_write,
    output logic                  b_grant,
    output logic                  b_rvalid,

    output logic [WORD_SIZE-1:0]  read_data,
    input  logic                  debug_hold,

    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [WORD_SIZE-1:0]  mem_write,
    output logic                  mem_wren,
    input  logic [WORD_SIZE-1:0]  mem_read,

    output logic [15:0]           conflict_count
);

    typedef enum logic {OwnerA, OwnerB} owner_e;

    owner_e      last_owner_q;
    logic        a_rvalid_q;
    logic        b_rvalid_q;
    logic [15:0] conflict_count_q;

    logic        eff_a;
    logic        eff_b;
    logic        conflict;

    always_comb begin
        eff_a    = a_req & ~debug_hold;
        eff_b    = b_req;
        conflict = reset_n & eff_a & eff_b;
        a_grant  = 1'b0;
        b_grant  = 1'b0;
        if (reset_n) begin
            if (eff_a && eff_b) begin
                // Contested cycle goes to whichever port did not own the previous access.
                if (last_owner_q == OwnerB) begin
                    a_grant = 1'b1;
                end else begin
                    b_grant = 1'b1;
                end
            end else begin
                a_grant = eff_a;
                b_grant = eff_b;
            end
        end
    end

    always_comb begin
        mem_address = b_address;
        mem_write   = b_write;
        if (a_grant) begin
            mem_address = a_address;
            mem_write   = a_write;
        end
        mem_wren = (a_grant & a_we) | (b_grant & b_we);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            last_owner_q     <= OwnerB;
            a_rvalid_q       <= 1'b0;
            b_rvalid_q       <= 1'b0;
            conflict_count_q <= 16'h0000;
        end else begin
            if (a_grant) begin
                last_owner_q <= OwnerA;
            end else if (b_grant) begin
                last_owner_q <= OwnerB;
            end
            a_rvalid_q <= a_grant & ~a_we;
            b_rvalid_q <= b_grant & ~b_we;
            if (conflict && conflict_count_q != 16'hFFFF) begin
                conflict_count_q <= conflict_count_q + 16'h0001;
            end
        end
    end

    // A reset arriving in the response cycle discards the read in flight.
    assign a_rvalid       = a_rvalid_q & reset_n;
    assign b_rvalid       = b_rvalid_q & reset_n;
    assign read_data      = mem_read;
    assign conflict_count = conflict_count_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a vector table for the single-cycle behaviour plus
// hand-written sequences for round-robin, reset during a read and counter saturation.
module tb_data_mem_arbiter;

    logic        clock;
    logic        reset_n;
    logic        a_req, a_we, b_req, b_we, debug_hold;
    logic [15:0] a_address, b_address;
    logic [17:0] a_write, b_write;
    logic        a_grant, a_rvalid, b_grant, b_rvalid;
    logic [17:0] read_data;
    logic [15:0] mem_address;
    logic [17:0] mem_write;
    logic        mem_wren;
    logic [17:0] mem_read;
    logic [15:0] conflict_count;

    int tests_run;
    int tests_failed;

    data_mem_arbiter #(.WORD_SIZE(18), .ADDR_WIDTH(16)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .a_req          (a_req),
        .a_we           (a_we),
        .a_address      (a_address),
        .a_write        (a_write),
        .a_grant        (a_grant),
        .a_rvalid       (a_rvalid),
        .b_req          (b_req),
        .b_we           (b_we),
        .b_address      (b_address),
        .b_write        (b_write),
        .b_grant        (b_grant),
        .b_rvalid       (b_rvalid),
        .read_data      (read_data),
        .debug_hold     (debug_hold),
        .mem_address    (mem_address),
        .mem_write      (mem_write),
        .mem_wren       (mem_wren),
        .mem_read       (mem_read),
        .conflict_count (conflict_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous RAM model; every word preloaded with 0x2A000 ^ address.
    logic [17:0] ram [0:65535];
    logic        ram_fill;

    always @(posedge clock) begin
        if (ram_fill) begin
            for (int i = 0; i < 65536; i++) begin
                ram[i] <= 18'h2A000 ^ 18'(i);
            end
        end else begin
            if (mem_wren) ram[mem_address] <= mem_write;
            mem_read <= ram[mem_address];
        end
    end

    typedef struct {
        logic        a_req, a_we;
        logic [15:0] a_addr;
        logic [17:0] a_wd;
        logic        b_req, b_we;
        logic [15:0] b_addr;
        logic [17:0] b_wd;
        logic        hold;
        logic        e_ag, e_bg, e_wren;
        logic [15:0] e_maddr;
        logic [17:0] e_mwr;
        logic        e_arv, e_brv;
        logic [17:0] e_rd;
        logic [15:0] e_cc;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        a_req = 1'b0; a_we = 1'b0; a_address = 16'h0; a_write = 18'h0;
        b_req = 1'b0; b_we = 1'b0; b_address = 16'h0; b_write = 18'h0;
        debug_hold = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        a_req = 1'b1;
        b_req = 1'b1;
        a_we  = 1'b1;
        reset_n = 1'b0;
        #2;
        chk("reset_a_grant", 32'(a_grant), 32'h0);
        chk("reset_b_grant", 32'(b_grant), 32'h0);
        chk("reset_wren", 32'(mem_wren), 32'h0);
        cyc();
        cyc();
        idle_inputs();
        reset_n = 1'b1;
        #2;
        chk("post_reset_a_rvalid", 32'(a_rvalid), 32'h0);
        chk("post_reset_b_rvalid", 32'(b_rvalid), 32'h0);
        chk("post_reset_count", 32'(conflict_count), 32'h0);
        cyc();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        idle_inputs();
        reset_n  = 1'b0;
        ram_fill = 1'b1;
        cyc();
        ram_fill = 1'b0;

        //        a_req  a_we  a_addr    a_wd       b_req  b_we  b_addr    b_wd       hold
        //        ag     bg    wren  maddr     mwr        arv    brv   rd         cc
        vecs[0]  = '{1'b1, 1'b0, 16'h0005, 18'h00000, 1'b1, 1'b0, 16'h0009, 18'h00000, 1'b0,
                     1'b1, 1'b0, 1'b0, 16'h0005, 18'h00000, 1'b0, 1'b0, 18'h00000, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0005, 18'h00000, 1'b1, 1'b0, 16'h0009, 18'h00000, 1'b0,
                     1'b0, 1'b1, 1'b0, 16'h0009, 18'h00000, 1'b1, 1'b0, 18'h2A005, 16'd1};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 18'h00000, 1'b0, 1'b0, 16'h0077, 18'h00000, 1'b0,
                     1'b0, 1'b0, 1'b0, 16'h0077, 18'h00000, 1'b0, 1'b1, 18'h2A009, 16'd1};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 18'h00000, 1'b1, 1'b1, 16'h0010, 18'h3FFFF, 1'b0,
                     1'b0, 1'b1, 1'b1, 16'h0010, 18'h3FFFF, 1'b0, 1'b0, 18'h00000, 16'd1};
        vecs[4]  = '{1'b1, 1'b0, 16'h0010, 18'h00000, 1'b0, 1'b0, 16'h0000, 18'h00000, 1'b0,
                     1'b1, 1'b0, 1'b0, 16'h0010, 18'h00000, 1'b0, 1'b0, 18'h00000, 16'd1};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 18'h00000, 1'b0, 1'b0, 16'h0000, 18'h00000, 1'b0,
                     1'b0, 1'b0, 1'b0, 16'h0000, 18'h00000, 1'b1, 1'b0, 18'h3FFFF, 16'd1};
        vecs[6]  = '{1'b1, 1'b1, 16'h0020, 18'h12345, 1'b0, 1'b0, 16'h0000, 18'h00000, 1'b0,
                     1'b1, 1'b0, 1'b1, 16'h0020, 18'h12345, 1'b0, 1'b0, 18'h00000, 16'd1};
        vecs[7]  = '{1'b1, 1'b0, 16'h0021, 18'h00000, 1'b1, 1'b0, 16'h0022, 18'h00000, 1'b0,
                     1'b0, 1'b1, 1'b0, 16'h0022, 18'h00000, 1'b0, 1'b0, 18'h00000, 16'd1};
        vecs[8]  = '{1'b1, 1'b0, 16'h0021, 18'h00000, 1'b1, 1'b0, 16'h0023, 18'h00000, 1'b0,
                     1'b1, 1'b0, 1'b0, 16'h0021, 18'h00000, 1'b0, 1'b1, 18'h2A022, 16'd2};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 18'h00000, 1'b1, 1'b0, 16'h0023, 18'h00000, 1'b0,
                     1'b0, 1'b1, 1'b0, 16'h0023, 18'h00000, 1'b1, 1'b0, 18'h2A021, 16'd3};
        vecs[10] = '{1'b1, 1'b0, 16'h0030, 18'h00000, 1'b0, 1'b0, 16'h0031, 18'h00000, 1'b1,
                     1'b0, 1'b0, 1'b0, 16'h0031, 18'h00000, 1'b0, 1'b1, 18'h2A023, 16'd3};
        vecs[11] = '{1'b1, 1'b0, 16'h0030, 18'h00000, 1'b1, 1'b0, 16'h0032, 18'h00000, 1'b1,
                     1'b0, 1'b1, 1'b0, 16'h0032, 18'h00000, 1'b0, 1'b0, 18'h00000, 16'd3};
        vecs[12] = '{1'b1, 1'b0, 16'h0030, 18'h00000, 1'b0, 1'b0, 16'h0000, 18'h00000, 1'b0,
                     1'b1, 1'b0, 1'b0, 16'h0030, 18'h00000, 1'b0, 1'b1, 18'h2A032, 16'd3};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 18'h00000, 1'b0, 1'b0, 16'h0000, 18'h00000, 1'b0,
                     1'b0, 1'b0, 1'b0, 16'h0000, 18'h00000, 1'b1, 1'b0, 18'h2A030, 16'd3};

        do_reset();

        for (int i = 0; i < 14; i++) begin
            a_req = vecs[i].a_req; a_we = vecs[i].a_we;
            a_address = vecs[i].a_addr; a_write = vecs[i].a_wd;
            b_req = vecs[i].b_req; b_we = vecs[i].b_we;
            b_address = vecs[i].b_addr; b_write = vecs[i].b_wd;
            debug_hold = vecs[i].hold;
            #2;
            chk($sformatf("v%0d_a_grant", i), 32'(a_grant), 32'(vecs[i].e_ag));
            chk($sformatf("v%0d_b_grant", i), 32'(b_grant), 32'(vecs[i].e_bg));
            chk($sformatf("v%0d_wren", i), 32'(mem_wren), 32'(vecs[i].e_wren));
            chk($sformatf("v%0d_mem_address", i), 32'(mem_address), 32'(vecs[i].e_maddr));
            chk($sformatf("v%0d_mem_write", i), 32'(mem_write), 32'(vecs[i].e_mwr));
            chk($sformatf("v%0d_a_rvalid", i), 32'(a_rvalid), 32'(vecs[i].e_arv));
            chk($sformatf("v%0d_b_rvalid", i), 32'(b_rvalid), 32'(vecs[i].e_brv));
            if (vecs[i].e_arv || vecs[i].e_brv) begin
                chk($sformatf("v%0d_read_data", i), 32'(read_data), 32'(vecs[i].e_rd));
            end
            chk($sformatf("v%0d_count", i), 32'(conflict_count), 32'(vecs[i].e_cc));
            cyc();
        end

        // Continuous contention: grants alternate starting with A.
        do_reset();
        a_req = 1'b1; b_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_address = 16'(i); b_address = 16'(i + 100);
            #2;
            chk($sformatf("rr%0d_a_grant", i), 32'(a_grant), 32'((i % 2) == 0));
            chk($sformatf("rr%0d_b_grant", i), 32'(b_grant), 32'((i % 2) == 1));
            cyc();
        end
        idle_inputs();
        #2;
        chk("rr_count", 32'(conflict_count), 32'd8);
        cyc();

        // Reset in the response cycle of a granted A read.
        do_reset();
        a_req = 1'b1; b_req = 1'b1; a_address = 16'h0001; b_address = 16'h0002;
        #2;
        chk("rst_pre_a_grant", 32'(a_grant), 32'h1);
        cyc();
        b_req = 1'b0; a_address = 16'h0005;
        #2;
        chk("rst_read_a_grant", 32'(a_grant), 32'h1);
        cyc();
        reset_n = 1'b0; a_req = 1'b1; b_req = 1'b1; a_we = 1'b1; b_we = 1'b1;
        #2;
        chk("rst_a_rvalid_suppressed", 32'(a_rvalid), 32'h0);
        chk("rst_a_grant", 32'(a_grant), 32'h0);
        chk("rst_b_grant", 32'(b_grant), 32'h0);
        chk("rst_wren", 32'(mem_wren), 32'h0);
        cyc();
        reset_n = 1'b1; a_we = 1'b0; b_we = 1'b0;
        #2;
        chk("rst_after_a_rvalid", 32'(a_rvalid), 32'h0);
        chk("rst_after_count", 32'(conflict_count), 32'h0);
        chk("rst_first_conflict_a", 32'(a_grant), 32'h1);
        chk("rst_first_conflict_b", 32'(b_grant), 32'h0);
        cyc();

        // Saturation of the conflict counter.
        do_reset();
        a_req = 1'b1; b_req = 1'b1;
        for (int i = 0; i < 16'hFFFE; i++) cyc();
        #2;
        chk("sat_fffe", 32'(conflict_count), 32'hFFFE);
        cyc();
        cyc();
        #2;
        chk("sat_ffff", 32'(conflict_count), 32'hFFFF);
        cyc();
        #2;
        chk("sat_hold", 32'(conflict_count), 32'hFFFF);
        idle_inputs();
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
